// File: rtl/pb_soc_regbank.sv
// pb_soc_regbank: PicoBlaze port-bus register bank for UART, GPIO, interrupt controller and sim status
//  clk_i, rst_n_i            clock, synchronous active-low reset
//  addr_i, data_i, wr_i, rd_i  port bus in; data_o registered read data (latency 1)
//  uart_*                    UART control/status registers and tx_write/rx_read strobes
//  gpio_o, gpio_oe_o, gpio_i  per-channel output, output enable and synchronised input
//  irq_i, irq_o              async interrupt sources, registered request to the CPU
//  sim_status                testbench status register
module pb_soc_regbank #(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int NUM_GPIO = 2,
    parameter int NUM_INT  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [DW-1:0]          data_i,
    input  logic                   wr_i,
    input  logic                   rd_i,
    output logic [DW-1:0]          data_o,
    output logic [DW-1:0]          uart_baud_control,
    output logic [DW-1:0]          uart_baud_count,
    input  logic [DW-1:0]          uart_baud_status,
    output logic [DW-1:0]          uart_tx_data,
    output logic [DW-1:0]          uart_tx_control,
    input  logic [DW-1:0]          uart_fifo_status,
    input  logic [DW-1:0]          uart_rx_data,
    output logic                   uart_tx_write,
    output logic                   uart_rx_read,
    output logic [NUM_GPIO*DW-1:0] gpio_o,
    output logic [NUM_GPIO*DW-1:0] gpio_oe_o,
    input  logic [NUM_GPIO*DW-1:0] gpio_i,
    input  logic [NUM_INT-1:0]     irq_i,
    output logic                   irq_o,
    output logic [DW-1:0]          sim_status
);
    logic [NUM_INT-1:0]     irq_s1, irq_s, irq_p, irq_pend, irq_mask, irq_edge, irq_set, irq_clr;
    logic [NUM_GPIO*DW-1:0] gpio_s1, gpio_s;
    logic [DW-1:0]          rd_mux;

    // edge mode needs a rising transition of the synchronised line, level mode just the line
    assign irq_set = irq_s & ~(irq_edge & irq_p);
    assign irq_clr = (wr_i && addr_i == AW'(8'h21)) ? data_i[NUM_INT-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            AW'(8'h00): rd_mux = uart_baud_control;
            AW'(8'h01): rd_mux = uart_baud_count;
            AW'(8'h02): rd_mux = uart_baud_status;
            AW'(8'h03): rd_mux = uart_tx_data;
            AW'(8'h04): rd_mux = uart_tx_control;
            AW'(8'h05): rd_mux = uart_fifo_status;
            AW'(8'h06): rd_mux = uart_rx_data;
            AW'(8'h20): rd_mux = DW'(irq_mask);
            AW'(8'h21): rd_mux = DW'(irq_pend);
            AW'(8'h22): rd_mux = DW'(irq_s);
            AW'(8'h23): rd_mux = DW'(irq_edge);
            AW'(8'hFF): rd_mux = sim_status;
            default:    rd_mux = '0;
        endcase
        for (int k = 0; k < NUM_GPIO; k++) begin
            if (addr_i == AW'(16 + 4*k)) rd_mux = gpio_o[k*DW +: DW];
            if (addr_i == AW'(17 + 4*k)) rd_mux = gpio_oe_o[k*DW +: DW];
            if (addr_i == AW'(18 + 4*k)) rd_mux = gpio_s[k*DW +: DW];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_o            <= '0;
            uart_baud_control <= '0;
            uart_baud_count   <= '0;
            uart_tx_data      <= '0;
            uart_tx_control   <= '0;
            uart_tx_write     <= 1'b0;
            uart_rx_read      <= 1'b0;
            gpio_o            <= '0;
            gpio_oe_o         <= '0;
            gpio_s1           <= '0;
            gpio_s            <= '0;
            irq_s1            <= '0;
            irq_s             <= '0;
            irq_p             <= '0;
            irq_pend          <= '0;
            irq_mask          <= '1;
            irq_edge          <= '0;
            irq_o             <= 1'b0;
            sim_status        <= '0;
        end else begin
            if (rd_i) data_o <= rd_mux;
            uart_tx_write <= wr_i && addr_i == AW'(8'h03);
            uart_rx_read  <= rd_i && addr_i == AW'(8'h06);
            gpio_s1       <= gpio_i;
            gpio_s        <= gpio_s1;
            irq_s1        <= irq_i;
            irq_s         <= irq_s1;
            irq_p         <= irq_s;
            // a set on the same edge as a W1C clear wins
            irq_pend      <= (irq_pend & ~irq_clr) | irq_set;
            irq_o         <= |(irq_pend & ~irq_mask);
            if (wr_i) begin
                case (addr_i)
                    AW'(8'h00): uart_baud_control <= data_i;
                    AW'(8'h01): uart_baud_count   <= data_i;
                    AW'(8'h03): uart_tx_data      <= data_i;
                    AW'(8'h04): uart_tx_control   <= data_i;
                    AW'(8'h20): irq_mask          <= data_i[NUM_INT-1:0];
                    AW'(8'h23): irq_edge          <= data_i[NUM_INT-1:0];
                    AW'(8'hFF): sim_status        <= data_i;
                    default: ;
                endcase
                for (int k = 0; k < NUM_GPIO; k++) begin
                    if (addr_i == AW'(16 + 4*k)) gpio_o[k*DW +: DW]    <= data_i;
                    if (addr_i == AW'(17 + 4*k)) gpio_oe_o[k*DW +: DW] <= data_i;
                end
            end
        end
    end
endmodule
